fpu_seq: RTL

Multicycle sequencer for the single-precision floating-point datapath used by the float instruction class (Op = 2'b11). The main control FSM pulses `start` on entry to its float-execute state and holds there until `done`, then moves to float write-back. The block owns no arithmetic; it issues one-hot step strobes to the FP datapath and reads back status flags.

---
 rtl/fpu_seq_if.sv | 35 +++
 rtl/fpu_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fpu_seq_if.sv
// Port bundle between the float-execute control and the fpu_seq step sequencer.
// start is a one-cycle request that is honoured only while busy is low. done is
// a one-cycle pulse in the last busy cycle. The datapath flags are level signals
// that the sequencer reads in its current state.
interface fpu_seq_if;
   logic       start;
   logic       op;
   logic       special;
   logic [7:0] exp_diff;
   logic       mant_msb;
   logic       mant_ovf;
   logic       busy;
   logic       load_ops;
   logic       align_shift;
   logic       add_en;
   logic       mul_step;
   logic       norm_left;
   logic       norm_right;
   logic       round_en;
   logic       pack_en;
   logic       done;
   logic [3:0] dbg_state;

   modport master (
      output start, op, special, exp_diff, mant_msb, mant_ovf,
      input  busy, load_ops, align_shift, add_en, mul_step, norm_left,
             norm_right, round_en, pack_en, done, dbg_state
   );

   modport slave (
      input  start, op, special, exp_diff, mant_msb, mant_ovf,
      output busy, load_ops, align_shift, add_en, mul_step, norm_left,
             norm_right, round_en, pack_en, done, dbg_state
   );
endinterface

// File: rtl/fpu_seq.sv
// Multicycle step sequencer for single-precision FADD/FMUL. It issues one-hot
// strobes to the FP datapath and reads back its normalisation flags.
module fpu_seq #(
   parameter int ALIGN_MAX = 26,
   parameter int MUL_STEPS = 24,
   parameter int NORM_MAX  = 24
) (
   input logic        clk,
   input logic        reset,
   fpu_seq_if.slave   bus
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_UNPACK = 4'd1,
      S_ALIGN  = 4'd2,
      S_ADD    = 4'd3,
      S_MUL    = 4'd4,
      S_NORM   = 4'd5,
      S_ROUND  = 4'd6,
      S_PACK   = 4'd7,
      S_DONE   = 4'd8
   } state_t;

   state_t     state, state_nx;
   logic [4:0] cnt, cnt_nx;
   logic       op_q;
   logic [4:0] align_ld;

   // The alignment count saturates. Shifting past the mantissa width only sticks zeros.
   always_comb begin
      align_ld = 5'(bus.exp_diff - 8'd1);
      if (bus.exp_diff > 8'(ALIGN_MAX)) align_ld = 5'(ALIGN_MAX - 1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 5'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // The opcode is only consumed after the start edge, so it needs no reset.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && bus.start) op_q <= bus.op;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         S_IDLE:   if (bus.start) state_nx = S_UNPACK;
         S_UNPACK: begin
            if (bus.special) begin
               state_nx = S_PACK;
            end else if (op_q) begin
               state_nx = S_MUL;
               cnt_nx   = 5'(MUL_STEPS - 1);
            end else if (bus.exp_diff == 8'd0) begin
               state_nx = S_ADD;
            end else begin
               state_nx = S_ALIGN;
               cnt_nx   = align_ld;
            end
         end
         S_ALIGN: begin
            if (cnt == 5'd0) state_nx = S_ADD;
            else             cnt_nx   = cnt - 5'd1;
         end
         S_ADD: begin
            state_nx = S_NORM;
            cnt_nx   = 5'd0;
         end
         S_MUL: begin
            if (cnt == 5'd0) begin
               state_nx = S_NORM;
               cnt_nx   = 5'd0;
            end else begin
               cnt_nx = cnt - 5'd1;
            end
         end
         S_NORM: begin
            // In NORM, cnt counts left shifts. Hitting the cap means a zero or underflow result.
            if (bus.mant_ovf || bus.mant_msb || cnt == 5'(NORM_MAX)) state_nx = S_ROUND;
            else                                                    cnt_nx   = cnt + 5'd1;
         end
         S_ROUND: state_nx = S_PACK;
         S_PACK:  state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy        = (state != S_IDLE);
      bus.load_ops    = 1'b0;
      bus.align_shift = 1'b0;
      bus.add_en      = 1'b0;
      bus.mul_step    = 1'b0;
      bus.norm_left   = 1'b0;
      bus.norm_right  = 1'b0;
      bus.round_en    = 1'b0;
      bus.pack_en     = 1'b0;
      bus.done        = 1'b0;
      bus.dbg_state   = state;
      case (state)
         S_UNPACK: bus.load_ops    = 1'b1;
         S_ALIGN:  bus.align_shift = 1'b1;
         S_ADD:    bus.add_en      = 1'b1;
         S_MUL:    bus.mul_step    = 1'b1;
         S_NORM: begin
            bus.norm_right = bus.mant_ovf;
            bus.norm_left  = !bus.mant_ovf && !bus.mant_msb && (cnt != 5'(NORM_MAX));
         end
         S_ROUND:  bus.round_en    = 1'b1;
         S_PACK:   bus.pack_en     = 1'b1;
         S_DONE:   bus.done        = 1'b1;
         default:  ;
      endcase
   end

endmodule
